// File: rtl/phase_gen_pkg.sv
// -----------------------------------------------------------------------------
// phase_gen_pkg
//   Shared constants and helpers for the multi-phase clock generator.
//   - MAX_NPH        : largest supported phase count
//   - MAX_IDX_W      : phase-index width needed at MAX_NPH
//   - MAX_REQ_W      : phase-count request width needed at MAX_NPH
//   - clamp_nph()    : maps a requested phase count onto the legal range
// -----------------------------------------------------------------------------
package phase_gen_pkg;

  localparam int MAX_NPH   = 8;
  localparam int MAX_IDX_W = $clog2(MAX_NPH);
  localparam int MAX_REQ_W = $clog2(MAX_NPH + 1);

  // A rotation needs at least two phases to be meaningful, and can never use
  // more phases than the instance physically provides.
  function automatic int clamp_nph(input int req, input int nph);
    if (req < 2)
      return 2;
    else if (req > nph)
      return nph;
    else
      return req;
  endfunction

endpackage

// File: rtl/phase_gen_clockgater.sv
// -----------------------------------------------------------------------------
// phase_gen_clockgater
//   Latch-based integrated clock gate. The enable is captured by a latch that
//   is transparent while clk is low, so the gated clock can only start or stop
//   on a full high pulse and never glitches.
//   Ports:
//     clk  - free-running source clock
//     en1  - functional enable
//     en2  - test override enable (forces the clock through)
//     gclk - gated clock output
// -----------------------------------------------------------------------------
module phase_gen_clockgater (
  input  logic clk,
  input  logic en1,
  input  logic en2,
  output logic gclk
);

  logic en_lat;

  always_latch begin
    if (!clk)
      en_lat = en1 | en2;
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/phase_gen.sv
// -----------------------------------------------------------------------------
// phase_gen
//   Rotating N-phase sequencer with per-phase gated clocks. A phase index
//   counts 0 .. nph_cur-1 and wraps; the active phase count nph_cur is only
//   reloaded at a wrap, on resync or during reset, so a rotation in progress
//   is never truncated by a change of nph_req.
//   Parameters:
//     NPH     - number of phase outputs (2..8)
//     RST_PH  - phase index held during reset (0..NPH-1)
//   Ports:
//     clk       - clock, rising-edge active
//     reset     - asynchronous active-high reset
//     en        - advance enable (low stalls the current phase)
//     resync    - synchronous restart to phase 0, reloads nph_cur
//     nph_req   - requested active phase count (clamped to 2..NPH)
//     gate_mask - per-phase gated clock enable mask
//     test_en   - forces every gated clock to run
//     ph        - one-hot current phase
//     ph_idx    - binary current phase index
//     last_ph   - high while ph_idx is the final phase of the rotation
//     gclk      - per-phase gated clocks
// -----------------------------------------------------------------------------
module phase_gen
  import phase_gen_pkg::*;
#(
  parameter int NPH    = 3,
  parameter int RST_PH = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       resync,
  input  logic [$clog2(NPH+1)-1:0]   nph_req,
  input  logic [NPH-1:0]             gate_mask,
  input  logic                       test_en,
  output logic [NPH-1:0]             ph,
  output logic [$clog2(NPH)-1:0]     ph_idx,
  output logic                       last_ph,
  output logic [NPH-1:0]             gclk
);

  localparam int IW = $clog2(NPH);
  localparam int CW = $clog2(NPH + 1);

  logic [CW-1:0] nph_cur;
  logic [CW-1:0] nph_clamped;
  logic [CW-1:0] idx_ext;
  logic          idx_over;
  logic [NPH-1:0] ph_en;

  assign nph_clamped = CW'(clamp_nph(int'(nph_req), NPH));

  // Counter compare is done at the count width, which is never narrower than
  // the index width.
  assign idx_ext  = CW'(ph_idx);
  assign last_ph  = (idx_ext == (nph_cur - CW'(1)));
  // Only reachable when RST_PH lies beyond the count loaded during reset.
  assign idx_over = (idx_ext >= nph_cur);

  // ---- phase counter / active count registers ----
  // nph_cur loads from the live request while reset is held so that the
  // first rotation after release already uses the requested count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_idx  <= IW'(RST_PH);
      nph_cur <= nph_clamped;
    end else if (resync) begin
      ph_idx  <= '0;
      nph_cur <= nph_clamped;
    end else if (en) begin
      if (last_ph || idx_over)
        ph_idx <= '0;
      else
        ph_idx <= ph_idx + IW'(1);
      if (last_ph)
        nph_cur <= nph_clamped;
    end
  end

  // ---- one-hot decode (register-only fan-in) ----
  always_comb begin
    ph = '0;
    for (int i = 0; i < NPH; i++)
      ph[i] = (ph_idx == IW'(i));
  end

  // ---- per-phase clock gating ----
  // Reset suppresses the functional enable so no phase clock runs while the
  // sequencer is held; test_en still overrides through the gater.
  assign ph_en = ph & gate_mask & {NPH{en & ~reset}};

  for (genvar g = 0; g < NPH; g++) begin : g_gate
    phase_gen_clockgater u_cg (
      .clk  (clk),
      .en1  (ph_en[g]),
      .en2  (test_en),
      .gclk (gclk[g])
    );
  end

endmodule

// File: tb/tb_phase_gen.sv
module tb_phase_gen;

  localparam int NPH    = 4;
  localparam int RST_PH = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       resync;
  logic [2:0] nph_req;
  logic [3:0] gate_mask;
  logic       test_en;
  logic [3:0] ph;
  logic [1:0] ph_idx;
  logic       last_ph;
  logic [3:0] gclk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: current phase and active count, plain integers.
  int m_idx;
  int m_cnt;
  int pulses [4];

  phase_gen #(.NPH(NPH), .RST_PH(RST_PH)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .resync    (resync),
    .nph_req   (nph_req),
    .gate_mask (gate_mask),
    .test_en   (test_en),
    .ph        (ph),
    .ph_idx    (ph_idx),
    .last_ph   (last_ph),
    .gclk      (gclk)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampm(input int r);
    if (r < 2) return 2;
    if (r > NPH) return NPH;
    return r;
  endfunction

  // One clock edge of the specified behaviour.
  task automatic model_edge(input bit e, input bit rs, input int req);
    if (rs) begin
      m_idx = 0;
      m_cnt = clampm(req);
    end else if (e) begin
      if (m_idx == m_cnt - 1) begin
        m_idx = 0;
        m_cnt = clampm(req);
      end else begin
        m_idx = (m_idx + 1 < m_cnt) ? m_idx + 1 : 0;
      end
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_ph"},   32'(ph),      32'(1 << m_idx));
    check_val({tag, "_idx"},  32'(ph_idx),  32'(m_idx));
    check_val({tag, "_last"}, 32'(last_ph), 32'(m_idx == m_cnt - 1));
  endtask

  // Drive one cycle of inputs after the falling edge, then check after the
  // rising edge. A gated clock is high after the edge when its phase was the
  // current phase during the preceding low half and it was enabled.
  task automatic cyc(input bit e, input bit rs, input int req, input logic [3:0] gm, input bit te,
                     input string tag);
    logic [3:0] exp_g;
    @(negedge clk);
    en        = e;
    resync    = rs;
    nph_req   = 3'(req);
    gate_mask = gm;
    test_en   = te;
    exp_g = te ? 4'hF : (e ? (gm & 4'(1 << m_idx)) : 4'h0);
    @(posedge clk);
    model_edge(e, rs, req);
    #1;
    check_state(tag);
    check_val({tag, "_gclk"}, 32'(gclk), 32'(exp_g));
    for (int i = 0; i < 4; i++) pulses[i] += int'(gclk[i]);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0)
      check_val("onehot", 32'($onehot(ph)), 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b1; resync = 1'b0; test_en = 1'b0;
    gate_mask = 4'hF; nph_req = 3'd1;

    // Reset state, count loaded from request during reset.
    repeat (2) @(posedge clk);
    #1;
    m_idx = RST_PH; m_cnt = clampm(1);
    check_state("rst_req1");
    check_val("rst_gclk_off", 32'(gclk), 32'h0);
    @(negedge clk); nph_req = 3'd4;
    @(posedge clk); #1; m_cnt = clampm(4);
    check_state("rst_req4");
    @(negedge clk); test_en = 1'b1;
    @(posedge clk); #1;
    check_val("rst_gclk_test", 32'(gclk), 32'hF);
    @(negedge clk); test_en = 1'b0; en = 1'b0; reset = 1'b0;

    // Basic rotation of four phases.
    for (int i = 0; i < 5; i++) cyc(1, 0, 4, 4'hF, 0, "rot4");

    // Count shrinks to 2 mid-rotation; current rotation completes first.
    for (int i = 0; i < 6; i++) cyc(1, 0, 2, 4'hF, 0, "shrink");

    // Stall at index 2 for three cycles.
    cyc(0, 1, 4, 4'hF, 0, "pre_stall");
    cyc(1, 0, 4, 4'hF, 0, "pre_stall");
    cyc(1, 0, 4, 4'hF, 0, "pre_stall");
    for (int i = 0; i < 3; i++) cyc(0, 0, 4, 4'hF, 0, "stall");
    cyc(1, 0, 4, 4'hF, 0, "resume");

    // Resync with en low from index 3, count reloads to 3.
    cyc(0, 1, 3, 4'hF, 0, "resync");
    for (int i = 0; i < 5; i++) cyc(1, 0, 3, 4'hF, 0, "cnt3");

    // Asynchronous reset mid-rotation together with resync.
    cyc(1, 0, 3, 4'hF, 0, "pre_arst");
    @(negedge clk);
    resync = 1'b1;
    #2 reset = 1'b1;
    #1;
    m_idx = RST_PH; m_cnt = clampm(int'(nph_req));
    check_state("arst_now");
    @(posedge clk); #1;
    check_state("arst_resync");
    @(negedge clk); reset = 1'b0; resync = 1'b0; en = 1'b0;

    // Clamping of out-of-range requests, observed through the wrap point.
    foreach (pulses[i]) pulses[i] = 0;
    begin
      int reqs [3] = '{0, 1, 7};
      for (int k = 0; k < 3; k++) begin
        cyc(0, 1, reqs[k], 4'hF, 0, "clamp_load");
        for (int i = 0; i < 5; i++) cyc(1, 0, reqs[k], 4'hF, 0, "clamp_run");
      end
    end

    // Gate mask: only phases 0 and 2 pulse, once per rotation.
    cyc(0, 1, 4, 4'b0101, 0, "mask_load");
    foreach (pulses[i]) pulses[i] = 0;
    for (int i = 0; i < 8; i++) cyc(1, 0, 4, 4'b0101, 0, "mask");
    check_val("mask_pulses0", 32'(pulses[0]), 32'd2);
    check_val("mask_pulses1", 32'(pulses[1]), 32'd0);
    check_val("mask_pulses2", 32'(pulses[2]), 32'd2);
    check_val("mask_pulses3", 32'(pulses[3]), 32'd0);

    // Test override runs every clock, enabled or not.
    for (int i = 0; i < 4; i++) cyc(i[0], 0, 4, 4'b0101, 1, "test_en");

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(3) != 0), ($urandom_range(9) == 0), int'($urandom_range(7)),
          4'($urandom), ($urandom_range(9) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
